sobel_grad: RTL

Parametrised, pipelined Sobel gradient unit for the Canny edge pipeline. Takes a flattened 3x3 greyscale window from the line-buffer stage and produces signed Gx/Gy, a saturated gradient magnitude and a 2-bit quantised direction for the non-maximum-suppression stage. It replaces the single-cycle, magnitude-only Sobel kernel, and adds valid/ready flow control, selectable magnitude approximation and direction binning.

---
 rtl/sobel_grad.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sobel_grad.sv
// sobel_grad: three-stage pipelined Sobel gradient unit.
// Produces signed Gx/Gy, a shifted and saturated magnitude and a 2-bit direction
// bin for non-maximum suppression. A single global enable stalls every stage together.
module sobel_grad #(
  parameter int unsigned PIXEL_W   = 8,
  parameter int unsigned MAG_W     = 8,
  parameter int unsigned MAG_SHIFT = 0,
  parameter int unsigned MAG_MODE  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [9*PIXEL_W-1:0]     pixels_g,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [PIXEL_W+2:0] gx,
  output logic signed [PIXEL_W+2:0] gy,
  output logic [MAG_W-1:0]         sobel_mag,
  output logic [1:0]               sobel_dir
);

  // Gradient width, absolute-value width, raw magnitude width, direction compare width.
  localparam int unsigned GW = PIXEL_W + 3;
  localparam int unsigned AW = PIXEL_W + 2;
  localparam int unsigned RW = PIXEL_W + 3;
  localparam int unsigned DW = PIXEL_W + 5;

  logic en_c;

  // Stage registers
  logic                 v1_q, v2_q, v3_q;
  logic signed [GW-1:0] gx1_q, gy1_q;
  logic signed [GW-1:0] gx2_q, gy2_q;
  logic [RW-1:0]        raw2_q;
  logic [1:0]           dir2_q;
  logic signed [GW-1:0] gx3_q, gy3_q;
  logic [MAG_W-1:0]     mag3_q;
  logic [1:0]           dir3_q;

  // Stage 1 combinational
  logic signed [GW-1:0] px_c [9];
  logic signed [GW-1:0] gx_d, gy_d;

  // Stage 2 combinational
  logic [AW-1:0] ax_c, ay_c, mx_c, mn_c;
  logic [DW-1:0] ax2_c, ay2_c, ax5_c, ay5_c;
  logic [RW-1:0] raw_d;
  logic [1:0]    dir_d;

  // Stage 3 combinational
  logic [RW-1:0]    shifted_c;
  logic [MAG_W-1:0] mag_d;

  // Global advance: everything moves unless a held result blocks the output.
  assign en_c     = !v3_q || out_ready;
  assign in_ready = en_c;

  // Unpack the window into sign-extended operands.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      px_c[k] = $signed(GW'(pixels_g[k*PIXEL_W +: PIXEL_W]));
    end
  end

  // Sobel kernels; results are exact in GW signed bits.
  always_comb begin
    gx_d = (px_c[2] + (px_c[5] <<< 1) + px_c[8]) - (px_c[0] + (px_c[3] <<< 1) + px_c[6]);
    gy_d = (px_c[0] + (px_c[1] <<< 1) + px_c[2]) - (px_c[6] + (px_c[7] <<< 1) + px_c[8]);
  end

  // Stage 1 register: gradients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      gx1_q <= '0;
      gy1_q <= '0;
    end else if (en_c) begin
      v1_q  <= in_valid;
      gx1_q <= gx_d;
      gy1_q <= gy_d;
    end
  end

  // Absolute values and magnitude approximation.
  always_comb begin
    ax_c = gx1_q[GW-1] ? AW'(-gx1_q) : AW'(gx1_q);
    ay_c = gy1_q[GW-1] ? AW'(-gy1_q) : AW'(gy1_q);
    if (ax_c >= ay_c) begin
      mx_c = ax_c;
      mn_c = ay_c;
    end else begin
      mx_c = ay_c;
      mn_c = ax_c;
    end
    if (MAG_MODE == 0) begin
      raw_d = RW'(ax_c) + RW'(ay_c);
    end else begin
      raw_d = RW'(mx_c) + RW'(mn_c >> 1);
    end
  end

  // Direction binning using tan(22.5)~2/5 and tan(67.5)~5/2 thresholds.
  always_comb begin
    ax2_c = DW'(ax_c) << 1;
    ay2_c = DW'(ay_c) << 1;
    ax5_c = (DW'(ax_c) << 2) + DW'(ax_c);
    ay5_c = (DW'(ay_c) << 2) + DW'(ay_c);
    dir_d = 2'd0;
    if ((ax_c == '0) && (ay_c == '0)) begin
      dir_d = 2'd0;
    end else if (ay5_c < ax2_c) begin
      dir_d = 2'd0;
    end else if (ay2_c > ax5_c) begin
      dir_d = 2'd2;
    end else if (gx1_q[GW-1] == gy1_q[GW-1]) begin
      dir_d = 2'd1;
    end else begin
      dir_d = 2'd3;
    end
  end

  // Stage 2 register: raw magnitude, direction, delayed gradients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      gx2_q  <= '0;
      gy2_q  <= '0;
      raw2_q <= '0;
      dir2_q <= 2'd0;
    end else if (en_c) begin
      v2_q   <= v1_q;
      gx2_q  <= gx1_q;
      gy2_q  <= gy1_q;
      raw2_q <= raw_d;
      dir2_q <= dir_d;
    end
  end

  assign shifted_c = raw2_q >> MAG_SHIFT;

  // Saturate only when the shifted magnitude can exceed the output width.
  generate
    if (MAG_W >= RW) begin : g_nosat
      assign mag_d = MAG_W'(shifted_c);
    end else begin : g_sat
      assign mag_d = (|shifted_c[RW-1:MAG_W]) ? {MAG_W{1'b1}} : shifted_c[MAG_W-1:0];
    end
  endgenerate

  // Stage 3 register: output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q   <= 1'b0;
      gx3_q  <= '0;
      gy3_q  <= '0;
      mag3_q <= '0;
      dir3_q <= 2'd0;
    end else if (en_c) begin
      v3_q   <= v2_q;
      gx3_q  <= gx2_q;
      gy3_q  <= gy2_q;
      mag3_q <= mag_d;
      dir3_q <= dir2_q;
    end
  end

  assign out_valid = v3_q;
  assign gx        = gx3_q;
  assign gy        = gy3_q;
  assign sobel_mag = mag3_q;
  assign sobel_dir = dir3_q;

endmodule
